// File: rtl/dm_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared constants and types for the two-port data-memory arbiter.
//   DATA_MEM_SIZE : data memory size in bytes
//   XLEN          : address / data width
//   arb_state_e   : arbiter FSM states (IDLE, ACCESS, RESP)
//   arb_req_t     : latched request payload (we, addr, wdata)
//   word_addr_bad : misaligned or past-the-last-word address test
// ----------------------------------------------------------------------------
package dm_arbiter_pkg;

    localparam int unsigned DATA_MEM_SIZE = 32;
    localparam int unsigned XLEN          = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } arb_req_t;

    // True when a word access at addr is unaligned or runs past the memory end.
    function automatic logic word_addr_bad(input logic [XLEN-1:0] addr,
                                           input int unsigned     mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > XLEN'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin winner select. Purely combinational; the last-grant
// bit is held by the caller.
//   req0_i, req1_i : pending requests
//   last_i         : id of the requester granted most recently
//   valid_c_o      : at least one request pending
//   win_c_o        : winning requester id (0 or 1)
// ----------------------------------------------------------------------------
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_c_o,
    output logic win_c_o
);

    assign valid_c_o = req0_i | req1_i;

    // On a tie the requester not granted last wins; otherwise the lone requester.
    assign win_c_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------------
// dm_arbiter
// Round-robin arbiter sharing one data memory between two requesters.
// Every transaction runs IDLE -> ACCESS -> RESP (3 cycles).
//
// Optional build macro: DM_ARB_BOUNDS_CHECK_EN
//   defined   : unaligned or out-of-range word addresses flag err, suppress
//               the write and return zero read data
//   undefined : err0/err1 tied low, no address check logic
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*         : requester 0/1 request payloads
//   gnt*                          : grant pulse, high for the ACCESS cycle
//   rvalid*/rdata*/err*           : response pulse, data and error flag
//   MemAddr/MemWriteData          : registered memory address / write data
//   MemWrite                      : memory write enable (combinational,
//                                   memory commits on negedge clk)
//   MemReadData                   : combinational memory read data
// ----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DATA_MEM_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [XLEN-1:0] addr0,
    input  logic [XLEN-1:0] addr1,
    input  logic [XLEN-1:0] wdata0,
    input  logic [XLEN-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [XLEN-1:0] rdata0,
    output logic [XLEN-1:0] rdata1,
    output logic            err0,
    output logic            err1,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWriteData,
    output logic            MemWrite,
    input  logic [XLEN-1:0] MemReadData
);

    if (MEM_BYTES != DATA_MEM_SIZE) begin : g_mem_size_check
        $error("dm_arbiter: MEM_BYTES must equal DATA_MEM_SIZE");
    end

    arb_state_e      state_q;
    arb_req_t        cur_q;
    arb_req_t        req_sel;
    logic            last_q;
    logic            id_q;
    logic            pick_valid;
    logic            pick_id;
    logic            gnt0_q;
    logic            gnt1_q;
    logic            rvalid0_q;
    logic            rvalid1_q;
    logic [XLEN-1:0] rdata0_q;
    logic [XLEN-1:0] rdata1_q;
    logic [XLEN-1:0] resp_data;

`ifdef DM_ARB_BOUNDS_CHECK_EN
    logic err_q;
    logic err0_q;
    logic err1_q;
    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    logic err_q;
    assign err_q = 1'b0;
    assign err0  = 1'b0;
    assign err1  = 1'b0;
`endif

    // Round-robin winner for the current IDLE cycle.
    rr_pick2 u_pick (
        .req0_i    (req0),
        .req1_i    (req1),
        .last_i    (last_q),
        .valid_c_o (pick_valid),
        .win_c_o   (pick_id)
    );

    // Winner's payload, latched on IDLE -> ACCESS.
    assign req_sel = pick_id ? '{we: we1, addr: addr1, wdata: wdata1}
                             : '{we: we0, addr: addr0, wdata: wdata0};

    // Faulted accesses answer with zero data.
    assign resp_data = err_q ? '0 : MemReadData;

    // rst gates the strobe in the same cycle so a reset mid-ACCESS never commits.
    assign MemWrite = (state_q == ACCESS) && cur_q.we && !rst && !err_q;

    assign MemAddr      = cur_q.addr;
    assign MemWriteData = cur_q.wdata;
    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;

    // Transaction FSM with registered grant/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;  // requester 0 wins the first tie
            id_q      <= 1'b0;
            cur_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef DM_ARB_BOUNDS_CHECK_EN
            err_q     <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`endif
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef DM_ARB_BOUNDS_CHECK_EN
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= ACCESS;
                        id_q    <= pick_id;
                        last_q  <= pick_id;
                        cur_q   <= req_sel;
                        gnt0_q  <= ~pick_id;
                        gnt1_q  <= pick_id;
`ifdef DM_ARB_BOUNDS_CHECK_EN
                        err_q   <= word_addr_bad(req_sel.addr, MEM_BYTES);
`endif
                    end
                end
                ACCESS: begin
                    // Memory wrote on the negedge, so reads here see post-write data.
                    state_q <= RESP;
                    if (id_q) begin
                        rvalid1_q <= 1'b1;
                        rdata1_q  <= resp_data;
`ifdef DM_ARB_BOUNDS_CHECK_EN
                        err1_q    <= err_q;
`endif
                    end else begin
                        rvalid0_q <= 1'b1;
                        rdata0_q  <= resp_data;
`ifdef DM_ARB_BOUNDS_CHECK_EN
                        err0_q    <= err_q;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dm_arbiter
// Drives two requester queues into dm_arbiter with a small word memory on
// the memory side, and predicts grants, bus values and responses from the
// arbitration rules (round robin, fixed 3-cycle transactions).
// Honours DM_ARB_BOUNDS_CHECK_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] MemAddr, MemWriteData, MemReadData;
    logic        MemWrite;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    int          gnt_log[$];
    logic [31:0] mem     [8];
    logic [31:0] ref_mem [8];
    logic        ref_last;
    logic [31:0] ref_rdata0, ref_rdata1, exp_addr, exp_wd;
    int          checks = 0;
    int          errors = 0;

    dm_arbiter #(.MEM_BYTES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .err0         (err0),
        .err1         (err1),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemReadData  (MemReadData)
    );

    always #5 clk = ~clk;

    // 32-byte word memory: combinational read, write on negedge.
    assign MemReadData = mem[MemAddr[4:2]];
    always @(negedge clk) begin
        if (MemWrite === 1'b1) mem[MemAddr[4:2]] = MemWriteData;
    end

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef DM_ARB_BOUNDS_CHECK_EN
        return (a[1:0] != 2'b00) || (a > 32'd28);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int who, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        if (who == 0) q0.push_back(t);
        else          q1.push_back(t);
    endtask

    // Each requester holds its queue head until granted; idle fields are junk.
    task automatic present();
        req0 = (q0.size() != 0);
        req1 = (q1.size() != 0);
        if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        else begin we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom; end
        if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
        else begin we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom; end
    endtask

    task automatic reset_model();
        ref_last   = 1'b1;
        ref_rdata0 = '0;
        ref_rdata1 = '0;
        exp_addr   = '0;
        exp_wd     = '0;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        present();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        reset_model();
    endtask

    // Drains both queues, checking every cycle against the arbitration rules.
    task automatic run_queues(input string tag);
        int          c = 0;
        int          next_gnt = 1;
        int          resp_due = -1;
        int          resp_idx = 0;
        logic        resp_id = 1'b0;
        logic        resp_err = 1'b0;
        logic [31:0] resp_data = '0;
        logic        exp_mw, w, e;
        logic [1:0]  exp_rv, exp_err;
        txn_t        t;
        present();
        while ((q0.size() != 0 || q1.size() != 0 || resp_due >= 0) && c < 200) begin
            step();
            c++;
            exp_mw = 1'b0;
            if (gnt0 === 1'b1 || gnt1 === 1'b1) gnt_log.push_back(int'(gnt1));
            if (c == next_gnt && (q0.size() != 0 || q1.size() != 0)) begin
                if (q0.size() != 0 && q1.size() != 0) w = ~ref_last;
                else                                  w = (q1.size() != 0);
                checks++;
                if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL %s grant cycle %0d: gnt1/gnt0=%b%b, required winner %0d",
                             tag, c, gnt1, gnt0, w);
                end
                if (w) t = q1.pop_front();
                else   t = q0.pop_front();
                e        = addr_bad(t.addr);
                exp_addr = t.addr;
                exp_wd   = t.wdata;
                exp_mw   = t.we & ~e;
                if (t.we && !e) ref_mem[t.addr[4:2]] = t.wdata;
                resp_idx  = int'(t.addr[4:2]);
                resp_data = e ? 32'h0 : ref_mem[resp_idx];
                resp_err  = e;
                resp_id   = w;
                resp_due  = c + 1;
                ref_last  = w;
                next_gnt  = c + 3;
            end else begin
                checks++;
                if ({gnt1, gnt0} !== 2'b00) begin
                    errors++;
                    $display("FAIL %s stray grant cycle %0d: gnt1/gnt0=%b%b, required 00",
                             tag, c, gnt1, gnt0);
                end
            end
            checks++;
            if (MemAddr !== exp_addr || MemWriteData !== exp_wd || MemWrite !== exp_mw) begin
                errors++;
                $display("FAIL %s mem bus cycle %0d: addr=%h wd=%h we=%b, required %h %h %b",
                         tag, c, MemAddr, MemWriteData, MemWrite, exp_addr, exp_wd, exp_mw);
            end
            exp_rv  = 2'b00;
            exp_err = 2'b00;
            if (c == resp_due) begin
                exp_rv  = resp_id ? 2'b10 : 2'b01;
                exp_err = resp_id ? {resp_err, 1'b0} : {1'b0, resp_err};
                if (resp_id) ref_rdata1 = resp_data;
                else         ref_rdata0 = resp_data;
                checks++;
                if (mem[resp_idx] !== ref_mem[resp_idx]) begin
                    errors++;
                    $display("FAIL %s memory word %0d: got %h, required %h",
                             tag, resp_idx, mem[resp_idx], ref_mem[resp_idx]);
                end
                resp_due = -1;
            end
            checks++;
            if ({rvalid1, rvalid0} !== exp_rv || {err1, err0} !== exp_err) begin
                errors++;
                $display("FAIL %s response cycle %0d: rvalid=%b err=%b, required %b %b",
                         tag, c, {rvalid1, rvalid0}, {err1, err0}, exp_rv, exp_err);
            end
            checks++;
            if (rdata0 !== ref_rdata0 || rdata1 !== ref_rdata1) begin
                errors++;
                $display("FAIL %s rdata cycle %0d: rdata0=%h rdata1=%h, required %h %h",
                         tag, c, rdata0, rdata1, ref_rdata0, ref_rdata1);
            end
            present();
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || resp_due >= 0) begin
            errors++;
            $display("FAIL %s timeout: %0d/%0d requests left, response pending=%0d, required 0/0/0",
                     tag, q0.size(), q1.size(), resp_due >= 0);
            q0.delete(); q1.delete();
            present();
        end
        step();  // RESP -> IDLE
    endtask

    task automatic test_reset();
        rst = 1'b1;
        q0.delete(); q1.delete();
        present();
        step(); step(); step();
        checks++;
        if ({gnt1, gnt0, rvalid1, rvalid0, err1, err0, MemWrite} !== 7'b0) begin
            errors++;
            $display("FAIL reset strobes: gnt=%b%b rvalid=%b%b err=%b%b MemWrite=%b, required all 0",
                     gnt1, gnt0, rvalid1, rvalid0, err1, err0, MemWrite);
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset rdata: %h %h, required 0 0", rdata0, rdata1);
        end
        checks++;
        if (MemAddr !== 32'h0 || MemWriteData !== 32'h0) begin
            errors++;
            $display("FAIL reset mem bus: %h %h, required 0 0", MemAddr, MemWriteData);
        end
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_write_read();
        push(0, 1'b1, 32'h00, 32'h11223344);
        run_queues("single_write");
        checks++;
        if (rdata0 !== 32'h11223344) begin
            errors++;
            $display("FAIL single_write rdata0: got %h, required 11223344", rdata0);
        end
    endtask

    task automatic test_tie();
        do_reset();
        gnt_log.delete();
        push(0, 1'b0, 32'h00, 32'h0);
        push(1, 1'b0, 32'h14, 32'h0);
        push(0, 1'b0, 32'h10, 32'h0);  // requester 0 comes straight back: a second tie
        run_queues("tie");
        checks++;
        if (gnt_log.size() != 3 || gnt_log[0] != 0 || gnt_log[1] != 1 || gnt_log[2] != 0) begin
            errors++;
            $display("FAIL tie order: got %p, required '{0, 1, 0}", gnt_log);
        end
    endtask

    task automatic test_cross_port();
        push(1, 1'b1, 32'h08, 32'hDEADBEEF);
        run_queues("cross_write");
        push(0, 1'b0, 32'h08, 32'h0);
        run_queues("cross_read");
        checks++;
        if (rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cross_read rdata0: got %h, required deadbeef", rdata0);
        end
    endtask

    task automatic test_reset_during_access();
        push(0, 1'b1, 32'h04, 32'hAAAAAAAA);
        run_queues("preload");
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h04; wdata0 = 32'h55555555;
        step();
        checks++;
        if (gnt0 !== 1'b1 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL rst_access grant: gnt0=%b MemWrite=%b, required 1 1", gnt0, MemWrite);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_access MemWrite: got %b, required 0", MemWrite);
        end
        req0 = 1'b0;
        step();
        step();
        checks++;
        if ({rvalid1, rvalid0, gnt1, gnt0} !== 4'b0 || MemAddr !== 32'h0 || rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL rst_access outputs: rvalid=%b%b gnt=%b%b addr=%h rdata0=%h, required zeros",
                     rvalid1, rvalid0, gnt1, gnt0, MemAddr, rdata0);
        end
        checks++;
        if (mem[1] !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL rst_access memory: got %h, required aaaaaaaa", mem[1]);
        end
        rst = 1'b0;
        reset_model();
        push(0, 1'b0, 32'h04, 32'h0);
        run_queues("rst_access_read");
    endtask

    task automatic test_bounds();
        push(0, 1'b1, 32'h1E, 32'hCAFEF00D);
        run_queues("bounds_1e");
        checks++;
`ifdef DM_ARB_BOUNDS_CHECK_EN
        if (rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL bounds_1e rdata0: got %h, required 0", rdata0);
        end
`else
        if (rdata0 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bounds_1e rdata0: got %h, required cafef00d", rdata0);
        end
`endif
        push(1, 1'b1, 32'h20, 32'h01020304);
        push(0, 1'b0, 32'h01, 32'h0);
        push(1, 1'b0, 32'h1C, 32'h0);
        run_queues("bounds_mix");
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int n0 = $urandom_range(0, 3);
            int n1 = $urandom_range(0, 3);
            for (int k = 0; k < n0 + n1; k++) begin
                logic [31:0] a;
                if ($urandom_range(0, 5) == 0) a = $urandom;
                else                           a = 32'($urandom_range(0, 7) * 4);
                push((k < n0) ? 0 : 1, 1'($urandom), a, $urandom);
            end
            run_queues("random");
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        reset_model();
        test_reset();
        test_write_read();
        test_tie();
        test_cross_port();
        test_reset_during_access();
        test_bounds();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 32, is the data memory size in bytes and SHALL equal the shared DATA_MEM_SIZE constant.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on posedge clk.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Ports req0/req1, input, 1: access request from requester 0/1.
REQ-005 Ports we0/we1, input, 1: 1 = word write, 0 = word read.
REQ-006 Ports addr0/addr1, input, 32: byte address of the big-endian word.
REQ-007 Ports wdata0/wdata1, input, 32: write data.
REQ-008 Ports gnt0/gnt1, output, 1: one-cycle grant pulse.
REQ-009 Ports rvalid0/rvalid1, output, 1: one-cycle response pulse; it pulses for reads and for writes.
REQ-010 Ports rdata0/rdata1, output, 32: read data, valid while rvalid is high.
REQ-011 Ports err0/err1, output, 1: error flag, valid while rvalid is high.
REQ-012 Port MemAddr, output, 32: address driven to data memory.
REQ-013 Port MemWriteData, output, 32: write data driven to data memory.
REQ-014 Port MemWrite, output, 1: write enable driven to data memory, which commits on negedge clk.
REQ-015 Port MemReadData, input, 32: combinational read data returned from data memory.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; each transaction takes exactly 3 cycles; IDLE is not re-entered until RESP completes.
REQ-017 IDLE: if req0 or req1 is sampled high at edge N, the FSM SHALL go to ACCESS at N+1.
REQ-018 On that transition, the arbiter SHALL latch the winner's we, addr and wdata, plus the winner ID.
REQ-019 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; a single request always wins.
REQ-020 gnt of the winner SHALL be high for exactly the ACCESS cycle.
REQ-021 Each requester SHALL hold req/we/addr/wdata stable until it sees gnt, then drop req within one cycle.
REQ-022 ACCESS: MemAddr and MemWriteData SHALL carry the latched values.
REQ-023 ACCESS: MemWrite SHALL equal latched we AND NOT rst AND NOT err_q.
REQ-024 Outside ACCESS, MemWrite SHALL be 0.
REQ-025 MemAddr and MemWriteData SHALL be registered and hold their last value outside ACCESS.
REQ-026 At the ACCESS->RESP edge, MemReadData SHALL be captured into the winner's rdata; writes capture post-write data.
REQ-027 RESP: the winner's rvalid and err SHALL pulse for one cycle, then the FSM SHALL go to IDLE.
REQ-028 The loser's request SHALL remain pending and SHALL win the next IDLE arbitration.
REQ-029 rdata of the non-winner SHALL hold its previous value.
REQ-030 The latched addr SHALL be passed through unmodified; the arbiter SHALL never perform address wrap-around.

Reset
REQ-031 rst high at a posedge SHALL force IDLE, gnt/rvalid/err/MemWrite = 0, rdata/MemAddr/MemWriteData = 0, and the RR pointer so requester 0 wins the first tie.
REQ-032 rst asserted during ACCESS SHALL suppress MemWrite in that same cycle (per REQ-023) and abort the transaction with no rvalid.

Configuration
REQ-033 Macro DM_ARB_BOUNDS_CHECK_EN defined: a request with addr[1:0] != 0 or addr > MEM_BYTES-4 SHALL set err_q.
REQ-034 With err_q set, MemWrite SHALL be suppressed, rdata SHALL be 0, and err SHALL pulse with rvalid.
REQ-035 Macro DM_ARB_BOUNDS_CHECK_EN undefined: err0/err1 SHALL be tied 0 and no address check logic SHALL exist.

Structure
REQ-036 The shared package SHALL hold DATA_MEM_SIZE (32) and the state enum typedef {IDLE, ACCESS, RESP}.
REQ-037 The round-robin pick (2 requests plus last-grant bit -> winner) SHALL be a sub-module rr_pick2.

Verification
REQ-038 After reset, req0 write addr 0x00 wdata 0x11223344 -> gnt0 at cycle +1, MemWrite=1 for one cycle, rvalid0 at +2, rdata0=0x11223344.
REQ-039 req0 and req1 high in the same cycle, both reads -> gnt0 first, then gnt1 3 cycles later; next tie -> gnt1 first.
REQ-040 Write 0xDEADBEEF by req1 at addr 0x08, then read by req0 at addr 0x08 -> rdata0=0xDEADBEEF, err0=0.
REQ-041 rst during ACCESS of a write to addr 0x04 holding 0xAAAAAAAA -> MemWrite stays 0, memory keeps 0xAAAAAAAA, no rvalid, FSM in IDLE.
REQ-042 With DM_ARB_BOUNDS_CHECK_EN, write addr 0x1E -> MemWrite stays 0, rvalid with err=1 and rdata=0; without the macro, err stays 0.
